blft_img_streamer: RTL and testbench

- Synthesizable source that feeds the bilateral-filter core's input port. It reads a raster image from a synchronous-read pixel memory and drives in_valid/in_addr/in_data toward blft.
- It observes blft's out_valid/finish to count result beats and report completion.
- It replaces the behavioural pattern generator on the input side for on-chip and FPGA test.

---
 rtl/blft_pkg.sv | 13 +
 rtl/blft_skid_buf.sv | 47 ++++
 rtl/blft_img_streamer.sv | 132 +++++++++++++
 tb/tb_blft_img_streamer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/blft_pkg.sv
// Shared types and defaults for the bilateral-filter input streamer.
package blft_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, WAIT_FIN} state_t;

  localparam int IMG_W_DEF  = 256;
  localparam int IMG_H_DEF  = 256;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  function automatic int n_pix(input int w, input int h);
    return w * h;
  endfunction
endpackage

// File: rtl/blft_skid_buf.sv
// One-entry skid register between the pixel memory read port and the in_* output registers.
// Catches the read that lands while hold is high and replays it first on release.
module blft_skid_buf
  import blft_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              rd_vld,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              pres_vld,
  output logic [ADDR_W-1:0] pres_addr,
  output logic [DATA_W-1:0] pres_data
);
  logic              skid_vld;
  logic [ADDR_W-1:0] skid_addr;
  logic [DATA_W-1:0] skid_data;

  // The skid entry is always older than the live read data, so it goes first.
  assign pres_vld  = !hold && (skid_vld || rd_vld);
  assign pres_addr = skid_vld ? skid_addr : rd_addr;
  assign pres_data = skid_vld ? skid_data : rd_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      skid_vld  <= 1'b0;
      skid_addr <= '0;
      skid_data <= '0;
    end else if (hold) begin
      if (rd_vld && !skid_vld) begin
        skid_vld  <= 1'b1;
        skid_addr <= rd_addr;
        skid_data <= rd_data;
      end
    end else if (skid_vld) begin
      skid_vld <= rd_vld;
      if (rd_vld) begin
        skid_addr <= rd_addr;
        skid_data <= rd_data;
      end
    end
  end
endmodule

// File: rtl/blft_img_streamer.sv
// Streams a raster image from a sync-read pixel memory into blft and counts its result beats.
// Optional pixel checksum on in_* beats when BLFT_STREAM_CKSUM_EN is defined.
module blft_img_streamer
  import blft_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              in_valid,
  output logic [ADDR_W-1:0] in_addr,
  output logic [DATA_W-1:0] in_data,
  input  logic              out_valid,
  input  logic              finish,
  output logic [ADDR_W:0]   out_cnt,
  output logic [15:0]       cksum
);
  // One extra bit so a full 2^ADDR_W frame still terminates.
  localparam logic [ADDR_W:0] N_PIX = (ADDR_W+1)'(n_pix(IMG_W, IMG_H));
  localparam logic [ADDR_W:0] LAST  = N_PIX - (ADDR_W+1)'(1);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   issue_cnt;
  logic              fin_lat, rd_vld, done_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic              pres_vld;
  logic [ADDR_W-1:0] pres_addr;
  logic [DATA_W-1:0] pres_data;
  logic              start_ok, last_issue, last_out, fin_seen;

  assign start_ok   = (state == IDLE) && start;
  assign mem_re     = (state == STREAM) && !hold;
  assign mem_addr   = issue_cnt[ADDR_W-1:0];
  assign last_issue = mem_re && (issue_cnt == LAST);
  assign last_out   = in_valid && ({1'b0, in_addr} == LAST);
  assign fin_seen   = fin_lat || finish;

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE:     if (start) state_nxt = STREAM;
      STREAM:   if (last_issue) state_nxt = DRAIN;
      DRAIN:    if (last_out) state_nxt = WAIT_FIN;
      WAIT_FIN: if (fin_seen) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      issue_cnt <= '0;
      fin_lat   <= 1'b0;
      rd_vld    <= 1'b0;
      rd_addr   <= '0;
      out_cnt   <= '0;
    end else begin
      state  <= state_nxt;
      done   <= done_nxt;
      rd_vld <= mem_re;
      if (start_ok)      busy <= 1'b1;
      else if (done_nxt) busy <= 1'b0;
      if (mem_re) begin
        rd_addr   <= mem_addr;
        issue_cnt <= issue_cnt + 1'b1;
      end
      if (start_ok) begin
        issue_cnt <= '0;
        fin_lat   <= 1'b0;
        out_cnt   <= '0;
      end else begin
        if (busy && finish) fin_lat <= 1'b1;
        if (busy && out_valid && (out_cnt != N_PIX)) out_cnt <= out_cnt + 1'b1;
      end
    end
  end

  blft_skid_buf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .hold     (hold),
    .rd_vld   (rd_vld),
    .rd_addr  (rd_addr),
    .rd_data  (mem_rdata),
    .pres_vld (pres_vld),
    .pres_addr(pres_addr),
    .pres_data(pres_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_valid <= 1'b0;
      in_addr  <= '0;
      in_data  <= '0;
    end else begin
      in_valid <= pres_vld;
      if (pres_vld) begin
        in_addr <= pres_addr;
        in_data <= pres_data;
      end
    end
  end

`ifdef BLFT_STREAM_CKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst)          cksum <= '0;
    else if (start_ok) cksum <= '0;
    else if (in_valid) cksum <= cksum + 16'(in_data);
  end
`else
  assign cksum = '0;
`endif
endmodule

// File: tb/tb_blft_img_streamer.sv
// Self-checking bench for blft_img_streamer: directed frame table, mid-frame reset, random hold frames.
module tb_blft_img_streamer;
  localparam int IMG_W = 4, IMG_H = 4, ADDR_W = 4, DATA_W = 8;
  localparam int N = IMG_W * IMG_H;
`ifdef BLFT_STREAM_CKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, hold = 1'b0, out_valid = 1'b0, finish = 1'b0;
  logic busy, done, mem_re, in_valid;
  logic [ADDR_W-1:0] mem_addr, in_addr;
  logic [DATA_W-1:0] mem_rdata, in_data;
  logic [ADDR_W:0]   out_cnt;
  logic [15:0]       cksum;
  logic [DATA_W-1:0] mem [N];

  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;

  blft_img_streamer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .busy(busy), .done(done),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .out_valid(out_valid), .finish(finish), .out_cnt(out_cnt), .cksum(cksum)
  );

  // Synchronous-read memory; data outside the valid slot is scrambled.
  always @(posedge clk) mem_rdata <= mem_re ? mem[mem_addr] : DATA_W'($urandom);

  // Reference model: pending reads queued with their issue cycle, presented in order when data has arrived.
  bit          m_busy = 0, m_done = 0, m_vld = 0, m_fin = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_data = '0;
  logic [15:0] m_sum = '0;
  int          m_next = N, m_pres = 0, m_last = -1, m_cnt = 0;
  int          pend_a[$], pend_c[$];
  int          f_t0, f_first, f_last, f_done, f_beats, f_ndone;

  typedef struct {
    int h_lo, h_hi, fin_c, n_ov, re_c;
    int e_first, e_last, e_done, e_cnt;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs, compare outputs mid-cycle, advance model to next cycle.
  task automatic step(input bit st, input bit hd, input bit fn, input bit ov, input bit rs);
    bit exp_re, was_busy, nv, nd;
    start = st; hold = hd; finish = fn; out_valid = ov; rst = rs;
    @(negedge clk);
    exp_re = m_busy && (m_next < N) && !hd;
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("in_valid", in_valid, m_vld);
    if (m_vld) begin
      chk("in_addr", in_addr, m_addr);
      chk("in_data", in_data, m_data);
    end
    chk("mem_re", mem_re, exp_re);
    if (exp_re) chk("mem_addr", mem_addr, m_next[ADDR_W-1:0]);
    chk("out_cnt", out_cnt, m_cnt);
    chk("cksum", cksum, CK_EN ? m_sum : 16'h0);
    if (in_valid) begin
      if (f_first < 0) f_first = cyc - f_t0;
      f_last = cyc - f_t0;
      f_beats++;
    end
    if (done) begin
      f_done = cyc - f_t0;
      f_ndone++;
    end
    if (!rs) begin
      m_busy = 0; m_done = 0; m_vld = 0; m_fin = 0; m_addr = '0; m_data = '0;
      m_sum = '0; m_next = N; m_pres = 0; m_last = -1; m_cnt = 0;
      pend_a.delete(); pend_c.delete();
    end else begin
      was_busy = m_busy;
      nv = 0;
      if (m_vld) m_sum = m_sum + 16'(m_data);
      if (was_busy && fn) m_fin = 1;
      if (was_busy && ov && m_cnt < N) m_cnt++;
      nd = was_busy && (m_pres == N) && (m_last < cyc) && m_fin;
      if (exp_re) begin
        pend_a.push_back(m_next);
        pend_c.push_back(cyc);
        m_next++;
      end
      if (!hd && pend_a.size() > 0 && pend_c[0] < cyc) begin
        m_addr = pend_a.pop_front()[ADDR_W-1:0];
        void'(pend_c.pop_front());
        m_data = mem[m_addr];
        nv = 1;
        m_pres++;
        m_last = cyc + 1;
      end
      m_vld = nv;
      m_done = nd;
      if (nd) m_busy = 0;
      if (!was_busy && st) begin
        m_busy = 1; m_next = 0; m_cnt = 0; m_sum = '0; m_fin = 0; m_pres = 0; m_last = -1;
        pend_a.delete(); pend_c.delete();
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  // Start at relative cycle 0; run until two cycles past done or a cycle budget expires.
  task automatic run_frame(input int h_lo, input int h_hi, input int fin_c, input int n_ov,
                           input int re_c, input bit rnd);
    bit hd, ov, st;
    f_t0 = cyc; f_first = -1; f_last = -1; f_done = -1; f_beats = 0; f_ndone = 0;
    step(1, 0, 0, 0, 1);
    for (int k = 1; k < 250; k++) begin
      hd = rnd ? ($urandom_range(0, 9) < 3) : (k >= h_lo && k <= h_hi);
      ov = rnd ? 1'($urandom_range(0, 1)) : (k <= n_ov);
      st = (k == re_c) || (rnd && m_busy && $urandom_range(0, 15) == 0);
      step(st, hd, k == fin_c, ov, 1);
      if (f_ndone > 0 && k >= f_done + 2) break;
    end
    chk("done_pulses", f_ndone, 1);
    chk("beats", f_beats, N);
  endtask

  initial begin
    int ck;
    tbl[0] = '{-1, -1, 25,  0, -1, 3, 18, 26,  0};
    tbl[1] = '{ 5,  7, 25,  0, -1, 3, 21, 26,  0};
    tbl[2] = '{-1, -1, 10,  0, -1, 3, 18, 20,  0};
    tbl[3] = '{-1, -1, 25, 20,  8, 3, 18, 26, 16};
    tbl[4] = '{ 1,  2, 21,  0, -1, 5, 20, 22,  0};
    tbl[5] = '{17, 19, 12,  0, -1, 3, 21, 23,  0};
    tbl[6] = '{-1, -1, 19,  5, -1, 3, 18, 20,  5};
    for (int i = 0; i < N; i++) mem[i] = DATA_W'(i + 16);
    f_t0 = 0; f_first = -1; f_last = -1; f_done = -1; f_beats = 0; f_ndone = 0;

    rst = 1'b0;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0);
    step(0, 1, 0, 0, 1);

    ck = 0;
    for (int i = 0; i < N; i++) ck += i + 16;
    for (int t = 0; t < 7; t++) begin
      run_frame(tbl[t].h_lo, tbl[t].h_hi, tbl[t].fin_c, tbl[t].n_ov, tbl[t].re_c, 0);
      chk("first_valid", f_first, tbl[t].e_first);
      chk("last_valid", f_last, tbl[t].e_last);
      chk("done_cycle", f_done, tbl[t].e_done);
      chk("busy_after", busy, 0);
      chk("out_cnt_final", out_cnt, tbl[t].e_cnt);
      chk("cksum_final", cksum, CK_EN ? ck : 0);
      step(0, 1, 0, 1, 1);
    end

    // Mid-frame reset: rst low in cycle 7 clears everything at the edge into cycle 8.
    f_t0 = cyc; f_ndone = 0;
    step(1, 0, 0, 0, 1);
    for (int k = 1; k < 7; k++) step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    start = 0; hold = 0; finish = 0; out_valid = 0; rst = 1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_in_valid", in_valid, 0);
    chk("rst_in_addr", in_addr, 0);
    chk("rst_in_data", in_data, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_cksum", cksum, 0);
    @(posedge clk); #1;
    cyc++;
    for (int k = 0; k < 20; k++) step(0, 0, 1, 1, 1);
    chk("rst_no_done", f_ndone, 0);
    run_frame(-1, -1, 25, 0, -1, 0);
    chk("rst_first_valid", f_first, 3);

    // Randomized frames: random image, hold, out_valid, finish time, stray starts.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) mem[i] = DATA_W'($urandom);
      run_frame(-1, -1, $urandom_range(1, 60), 0, -1, 1);
      for (int k = 0; k < 3; k++) step(0, 1, 1, 1, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
